// File: rtl/dfp_uvector_scanner.sv
// Reads one uaddr/ucontrol frame over the DFP readback bus by pulsing the four strobes in turn.
// Define DFP_SCAN_CHANGE_EN to build the frame-change flag; otherwise changed is tied low.
module dfp_uvector_scanner #(
   parameter int unsigned SETTLE = 2,
   parameter int unsigned GAP    = 1
) (
   input  logic        clk2,
   input  logic        nreset,
   input  logic        nrsthold,
   input  logic        start,
   input  logic        continuous,
   input  logic [7:0]  fpd,
   output logic        nfpua0,
   output logic        nfpuc0,
   output logic        nfpuc1,
   output logic        nfpuc2,
   output logic        busy,
   output logic        done,
   output logic        valid,
   output logic [7:0]  uaddr_lo,
   output logic [23:0] ucontrol,
   output logic        changed
);

   localparam int unsigned MaxCnt = (SETTLE > GAP) ? SETTLE : GAP;
   localparam int unsigned CntW   = (MaxCnt > 1) ? $clog2(MaxCnt) : 1;
   localparam logic [CntW-1:0] SettleLast = CntW'(SETTLE - 1);
   localparam logic [CntW-1:0] GapLast    = CntW'(GAP - 1);

   typedef enum logic [1:0] {StIdle, StAssert, StGap, StDone} state_e;

   state_e          state_q, state_d;
   logic [1:0]      idx_q, idx_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            capture;
   logic            commit;
   logic [3:0]      strb_q, strb_d;
   logic [7:0]      shadow_q [4];
   logic            valid_q;
   logic [7:0]      uaddr_q;
   logic [23:0]     ucontrol_q;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      capture = 1'b0;
      if (state_q != StIdle && !nrsthold) begin
         state_d = StIdle;
         idx_d   = '0;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (start && nrsthold) begin
                  state_d = StAssert;
                  idx_d   = '0;
                  cnt_d   = '0;
               end
            end
            StAssert: begin
               if (cnt_q == SettleLast) begin
                  capture = 1'b1;
                  state_d = StGap;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CntW'(1);
               end
            end
            StGap: begin
               if (cnt_q == GapLast) begin
                  cnt_d = '0;
                  if (idx_q == 2'd3) begin
                     state_d = StDone;
                  end else begin
                     state_d = StAssert;
                     idx_d   = idx_q + 2'd1;
                  end
               end else begin
                  cnt_d = cnt_q + CntW'(1);
               end
            end
            StDone: begin
               cnt_d   = '0;
               idx_d   = '0;
               state_d = (continuous || start) ? StAssert : StIdle;
            end
            default: state_d = StIdle;
         endcase
      end
   end

   // Only a full, unaborted frame reaches DONE, so entry into DONE is the commit point.
   assign commit = (state_q == StGap) && (state_d == StDone);

   always_comb begin
      strb_d = 4'hF;
      if (state_d == StAssert) begin
         strb_d[idx_d] = 1'b0;
      end
   end

   always_ff @(posedge clk2 or negedge nreset) begin
      if (!nreset) begin
         state_q    <= StIdle;
         idx_q      <= '0;
         cnt_q      <= '0;
         strb_q     <= 4'hF;
         valid_q    <= 1'b0;
         uaddr_q    <= '0;
         ucontrol_q <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         strb_q  <= strb_d;
         if (commit) begin
            valid_q    <= 1'b1;
            uaddr_q    <= shadow_q[0];
            ucontrol_q <= {shadow_q[3], shadow_q[2], shadow_q[1]};
         end
      end
   end

   always_ff @(posedge clk2 or negedge nreset) begin
      if (!nreset) begin
         for (int i = 0; i < 4; i++) begin
            shadow_q[i] <= '0;
         end
      end else if (capture) begin
         shadow_q[idx_q] <= fpd;
      end
   end

`ifdef DFP_SCAN_CHANGE_EN
   logic changed_q;

   always_ff @(posedge clk2 or negedge nreset) begin
      if (!nreset) begin
         changed_q <= 1'b0;
      end else if (commit) begin
         changed_q <= !valid_q ||
                      ({shadow_q[3], shadow_q[2], shadow_q[1], shadow_q[0]} !=
                       {ucontrol_q, uaddr_q});
      end
   end

   assign changed = changed_q && (state_q == StDone);
`else
   assign changed = 1'b0;
`endif

   assign nfpua0   = strb_q[0];
   assign nfpuc0   = strb_q[1];
   assign nfpuc1   = strb_q[2];
   assign nfpuc2   = strb_q[3];
   assign busy     = (state_q != StIdle);
   assign done     = (state_q == StDone);
   assign valid    = valid_q;
   assign uaddr_lo = uaddr_q;
   assign ucontrol = ucontrol_q;

endmodule

// File: tb/tb_dfp_uvector_scanner.sv
// Bench for dfp_uvector_scanner: two instances (default and SETTLE=4/GAP=2) share stimulus and
// are checked every cycle against a strobe-protocol/frame model plus directed literal checks.
module tb_dfp_uvector_scanner;

   localparam int S0 = 2;
   localparam int G0 = 1;
   localparam int S1 = 4;
   localparam int G1 = 2;
`ifdef DFP_SCAN_CHANGE_EN
   localparam logic CHG_EN = 1'b1;
`else
   localparam logic CHG_EN = 1'b0;
`endif

   logic        clk2 = 1'b0;
   logic        nreset, nrsthold, start, continuous;
   logic [7:0]  seq [4];
   logic [7:0]  fpd0, fpd1;
   logic [3:0]  sn0, sn1;
   logic        busy0, done0, valid0, ch0;
   logic        busy1, done1, valid1, ch1;
   logic [7:0]  ua0, ua1;
   logic [23:0] uc0, uc1;

   // Sequencer: drives the byte selected by whichever strobe is low.
   assign fpd0 = !sn0[0] ? seq[0] : !sn0[1] ? seq[1] : !sn0[2] ? seq[2] : !sn0[3] ? seq[3] : 8'hFF;
   assign fpd1 = !sn1[0] ? seq[0] : !sn1[1] ? seq[1] : !sn1[2] ? seq[2] : !sn1[3] ? seq[3] : 8'hFF;

   dfp_uvector_scanner #(.SETTLE(S0), .GAP(G0)) u0 (
      .clk2(clk2), .nreset(nreset), .nrsthold(nrsthold), .start(start), .continuous(continuous),
      .fpd(fpd0), .nfpua0(sn0[0]), .nfpuc0(sn0[1]), .nfpuc1(sn0[2]), .nfpuc2(sn0[3]),
      .busy(busy0), .done(done0), .valid(valid0), .uaddr_lo(ua0), .ucontrol(uc0), .changed(ch0)
   );

   dfp_uvector_scanner #(.SETTLE(S1), .GAP(G1)) u1 (
      .clk2(clk2), .nreset(nreset), .nrsthold(nrsthold), .start(start), .continuous(continuous),
      .fpd(fpd1), .nfpua0(sn1[0]), .nfpuc0(sn1[1]), .nfpuc1(sn1[2]), .nfpuc2(sn1[3]),
      .busy(busy1), .done(done1), .valid(valid1), .uaddr_lo(ua1), .ucontrol(uc1), .changed(ch1)
   );

   always #5 clk2 = ~clk2;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Model state, one slot per instance.
   int          run_idx [2];
   int          run_len [2];
   int          gap_len [2];
   int          pos     [2];
   int          fstart  [2];
   int          ndone   [2];
   logic [7:0]  fr      [2][4];
   logic [7:0]  m_ua    [2];
   logic [23:0] m_uc    [2];
   logic        m_valid [2];
   logic        done_prev [2];
   int          cyc = 0;
   logic        hold_prev;

   always @(posedge clk2) hold_prev <= nrsthold;

   task automatic model_check(input int d, input int st, input int gp, input logic [3:0] sn,
                              input logic bz, input logic dn, input logic vl, input logic [7:0] ua,
                              input logic [23:0] uc, input logic ch, input logic [7:0] fp);
      string       p;
      int          k, nlow;
      logic [7:0]  nua;
      logic [23:0] nuc;
      logic        expch;
      p = $sformatf("u%0d", d);
      if (!nreset) begin
         chk({p, "_rst_strobes"}, sn, 4'hF);
         chk({p, "_rst_busy"}, bz, 0);
         chk({p, "_rst_done"}, dn, 0);
         chk({p, "_rst_valid"}, vl, 0);
         chk({p, "_rst_uaddr"}, ua, 0);
         chk({p, "_rst_ucontrol"}, uc, 0);
         chk({p, "_rst_changed"}, ch, 0);
         run_idx[d] = -1; run_len[d] = 0; gap_len[d] = 100; pos[d] = 0;
         m_ua[d] = '0; m_uc[d] = '0; m_valid[d] = 1'b0; done_prev[d] = 1'b0;
         return;
      end
      if (hold_prev === 1'b0) begin
         run_idx[d] = -1;
         pos[d] = 0;
      end
      nlow = 0;
      k = -1;
      for (int i = 0; i < 4; i++) begin
         if (!sn[i]) begin
            nlow++;
            k = i;
         end
      end
      chk({p, "_one_low"}, 32'(nlow <= 1), 1);
      if (nlow == 1) begin
         if (run_idx[d] == k) begin
            run_len[d]++;
         end else begin
            chk({p, "_break_before_make"}, 32'(run_idx[d] == -1), 1);
            chk({p, "_gap_len"}, 32'(gap_len[d] >= gp), 1);
            if (k == 0) begin
               pos[d] = 0;
               fstart[d] = cyc;
            end
            chk({p, "_order"}, k, pos[d]);
            run_idx[d] = k;
            run_len[d] = 1;
         end
         chk({p, "_settle_max"}, 32'(run_len[d] <= st), 1);
         chk({p, "_busy_strobe"}, bz, 1);
         fr[d][k] = fp;
         gap_len[d] = 0;
      end else begin
         if (run_idx[d] != -1) begin
            chk({p, "_settle"}, run_len[d], st);
            pos[d] = run_idx[d] + 1;
            run_idx[d] = -1;
         end
         gap_len[d]++;
      end
      expch = 1'b0;
      if (dn) begin
         chk({p, "_done_frame"}, pos[d], 4);
         chk({p, "_done_time"}, cyc - fstart[d], 4 * (st + gp));
         chk({p, "_done_width"}, done_prev[d], 0);
         chk({p, "_busy_done"}, bz, 1);
         nua = fr[d][0];
         nuc = {fr[d][3], fr[d][2], fr[d][1]};
         expch = !m_valid[d] || (nua != m_ua[d]) || (nuc != m_uc[d]);
         m_ua[d] = nua;
         m_uc[d] = nuc;
         m_valid[d] = 1'b1;
         pos[d] = 0;
         ndone[d]++;
      end
      chk({p, "_uaddr"}, ua, m_ua[d]);
      chk({p, "_ucontrol"}, uc, m_uc[d]);
      chk({p, "_valid"}, vl, m_valid[d]);
      chk({p, "_changed"}, ch, expch & CHG_EN);
      done_prev[d] = dn;
   endtask

   always @(negedge clk2) begin
      cyc++;
      model_check(0, S0, G0, sn0, busy0, done0, valid0, ua0, uc0, ch0, fpd0);
      model_check(1, S1, G1, sn1, busy1, done1, valid1, ua1, uc1, ch1, fpd1);
   end

   // Call at a negedge: raises start for one edge, returns at the negedge showing done0.
   task automatic run_frame(input string name, output int t_low, output int t_done);
      int n;
      t_low = -1;
      t_done = -1;
      n = 0;
      start = 1'b1;
      while (n < 200 && t_done < 0) begin
         @(negedge clk2);
         n++;
         start = 1'b0;
         if (!sn0[0] && t_low < 0) t_low = n;
         if (done0) t_done = n;
      end
      if (t_done < 0) chk({name, "_timeout"}, 0, 1);
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      @(negedge clk2);
      while (n < 400 && (busy0 || busy1)) begin
         @(negedge clk2);
         n++;
      end
      if (busy0 || busy1) chk({name, "_idle_timeout"}, 0, 1);
   endtask

   logic [31:0] tab [3];
   int          tl, td, d0, n, got;
   int          tdone [3];

   initial begin
      tab[0] = 32'h44332211;
      tab[1] = 32'h88776655;
      tab[2] = 32'h78563412;
      nreset = 1'b0; nrsthold = 1'b1; start = 1'b0; continuous = 1'b0;
      seq[0] = 8'hA5; seq[1] = 8'h3C; seq[2] = 8'h81; seq[3] = 8'h7E;
      repeat (3) @(negedge clk2);
      chk("rst_busy", busy0, 0);
      chk("rst_uaddr", ua0, 0);
      #2 nreset = 1'b1;

      // Single frame: first strobe low to done is 4*(SETTLE+GAP) edges.
      @(negedge clk2);
      d0 = ndone[0];
      run_frame("t1", tl, td);
      chk("t1_latency", td - tl, 12);
      chk("t1_uaddr", ua0, 8'hA5);
      chk("t1_ucontrol", uc0, 24'h7E813C);
      chk("t1_valid", valid0, 1);
      chk("t1_changed", ch0, CHG_EN);
      wait_idle("t1");
      chk("t1_done_count", ndone[0] - d0, 1);
      chk("t1_u1_uaddr", ua1, 8'hA5);
      chk("t1_u1_ucontrol", uc1, 24'h7E813C);

      // Identical frame, then one with ucontrol[15:8] altered.
      run_frame("t6a", tl, td);
      chk("t6a_changed", ch0, 0);
      chk("t6a_uaddr", ua0, 8'hA5);
      wait_idle("t6a");
      seq[2] = 8'h99;
      run_frame("t6b", tl, td);
      chk("t6b_changed", ch0, CHG_EN);
      chk("t6b_ucontrol", uc0, 24'h7E993C);
      wait_idle("t6b");

      // Continuous: three frames, new data after each done; period 4*(SETTLE+GAP)+1 edges.
      for (int i = 0; i < 4; i++) seq[i] = tab[0][8*i +: 8];
      continuous = 1'b1;
      start = 1'b1;
      n = 0;
      got = 0;
      while (got < 3 && n < 200) begin
         @(negedge clk2);
         n++;
         start = 1'b0;
         if (done0) begin
            tdone[got] = n;
            chk("t3_uaddr", ua0, {24'h0, tab[got][7:0]});
            chk("t3_ucontrol", uc0, {8'h0, tab[got][31:8]});
            got++;
            if (got < 3) begin
               for (int i = 0; i < 4; i++) seq[i] = tab[got][8*i +: 8];
            end else begin
               continuous = 1'b0;
            end
         end
      end
      chk("t3_frames", got, 3);
      if (got == 3) begin
         chk("t3_period1", tdone[1] - tdone[0], 13);
         chk("t3_period2", tdone[2] - tdone[1], 13);
      end
      continuous = 1'b0;
      wait_idle("t3");

      // Abort while nfpuc1 is low.
      start = 1'b1;
      n = 0;
      do begin
         @(negedge clk2);
         n++;
         start = 1'b0;
      end while (sn0[2] && n < 100);
      if (sn0[2]) chk("t4_reach_uc1", 0, 1);
      d0 = ndone[0];
      nrsthold = 1'b0;
      @(negedge clk2);
      chk("t4_strobes", sn0, 4'hF);
      chk("t4_busy", busy0, 0);
      chk("t4_uaddr", ua0, 8'h12);
      chk("t4_ucontrol", uc0, 24'h785634);
      chk("t4_valid", valid0, 1);
      nrsthold = 1'b1;
      repeat (20) @(negedge clk2);
      chk("t4_no_done", ndone[0] - d0, 0);
      chk("t4_busy_after", busy0, 0);
      wait_idle("t4");

      // Asynchronous reset while nfpuc0 is low.
      start = 1'b1;
      n = 0;
      do begin
         @(negedge clk2);
         n++;
         start = 1'b0;
      end while (sn0[1] && n < 100);
      if (sn0[1]) chk("t5_reach_uc0", 0, 1);
      #2 nreset = 1'b0;
      #1;
      chk("t5_strobes0", sn0, 4'hF);
      chk("t5_strobes1", sn1, 4'hF);
      chk("t5_busy", busy0, 0);
      chk("t5_done", done0, 0);
      chk("t5_valid", valid0, 0);
      chk("t5_uaddr", ua0, 0);
      chk("t5_ucontrol", uc0, 0);
      chk("t5_changed", ch0, 0);
      @(negedge clk2);
      #2 nreset = 1'b1;
      @(negedge clk2);
      run_frame("t5_recover", tl, td);
      chk("t5r_uaddr", ua0, 8'h12);
      chk("t5r_ucontrol", uc0, 24'h785634);
      chk("t5r_changed", ch0, CHG_EN);
      wait_idle("t5r");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
